// File: rtl/rs_rom_arb.sv
// Round-robin arbiter sharing one registered GF(256) inv/log table among NREQ ports.
// Optional zero-operand flagging is enabled by defining RS_ROM_ARB_ZERO_CHK_EN.
module rs_rom_arb #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_op,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [8*NREQ-1:0] rsp_data,
    output logic [NREQ-1:0]   rsp_err,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [8:0]        rom_addr,
    input  logic [7:0]        rom_q
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   nxt_ptr;
    logic [PW-1:0]   s1_idx;
    logic [PW-1:0]   s2_idx;
    logic [NREQ-1:0] busy;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic            found;
    logic            s1_v;
    logic            s2_v;
    logic            sel_op;
    logic [7:0]      sel_data;
    int              j;

    // A port stays ineligible from acceptance until its response is consumed.
    assign elig = req_valid & ~busy;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && elig[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                gidx   = PW'(j);
            end
        end
    end

    always_comb begin
        sel_op   = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op   = req_op[i];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    assign req_ready = rst ? '0 : gnt;
    assign nxt_ptr   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

`ifdef RS_ROM_ARB_ZERO_CHK_EN
    logic s1_z;
    logic s2_z;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            busy      <= '0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            s1_idx    <= '0;
            s2_idx    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rom_addr  <= '0;
`ifdef RS_ROM_ARB_ZERO_CHK_EN
            s1_z      <= 1'b0;
            s2_z      <= 1'b0;
            rsp_err   <= '0;
`endif
        end else begin
            if (found) begin
                rr_ptr   <= nxt_ptr;
                rom_addr <= {sel_op, sel_data};
            end
            s1_v   <= found;
            s1_idx <= gidx;
            s2_v   <= s1_v;
            s2_idx <= s1_idx;
`ifdef RS_ROM_ARB_ZERO_CHK_EN
            s1_z   <= (sel_data == 8'd0);
            s2_z   <= s1_z;
`endif
            for (int k = 0; k < NREQ; k++) begin
                if (found && gnt[k]) busy[k] <= 1'b1;
                if (rsp_valid[k] && rsp_ready[k]) begin
                    rsp_valid[k] <= 1'b0;
                    busy[k]      <= 1'b0;
`ifdef RS_ROM_ARB_ZERO_CHK_EN
                    rsp_err[k]   <= 1'b0;
`endif
                end
                // rom_q now reflects the address registered two edges ago.
                if (s2_v && s2_idx == PW'(k)) begin
                    rsp_valid[k]       <= 1'b1;
                    rsp_data[8*k +: 8] <= rom_q;
`ifdef RS_ROM_ARB_ZERO_CHK_EN
                    rsp_err[k]         <= s2_z;
`endif
                end
            end
        end
    end

`ifndef RS_ROM_ARB_ZERO_CHK_EN
    assign rsp_err = '0;
`endif

endmodule

// File: tb/tb_rs_rom_arb.sv
// Directed bench for rs_rom_arb with a registered GF(256) inv/log table model.
// Expected rsp_err follows RS_ROM_ARB_ZERO_CHK_EN.
module tb_rs_rom_arb;

    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_op;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [8*NREQ-1:0] rsp_data;
    logic [NREQ-1:0]   rsp_err;
    logic [NREQ-1:0]   rsp_ready;
    logic [8:0]        rom_addr;
    logic [7:0]        rom_q;

    logic [7:0] rom [512];
    int tests;
    int fails;
    logic zexp;

    rs_rom_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_q <= rom[rom_addr];

    task automatic build_rom();
        int expt [256];
        int logt [256];
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            expt[i] = x;
            logt[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        rom[0]   = 8'd1;
        rom[256] = 8'd255;
        for (int a = 1; a < 256; a++) begin
            rom[a]       = 8'(expt[(255 - logt[a]) % 255]);
            rom[256 + a] = 8'(logt[a]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        repeat (2) @(negedge clk);
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_req_ready got %b exp 0000", req_ready);
        end
        tests++;
        if (rsp_valid !== 4'b0000 || rsp_err !== 4'b0000) begin
            fails++;
            $display("FAIL reset_rsp got v=%b e=%b exp 0/0", rsp_valid, rsp_err);
        end
        tests++;
        if (rsp_data !== 32'h0 || rom_addr !== 9'd0) begin
            fails++;
            $display("FAIL reset_data got d=%h a=%0d exp 0/0", rsp_data, rom_addr);
        end
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_inv();
        req_valid = 4'b0001;
        req_op = '0;
        req_data[7:0] = 8'd2;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL inv_grant got %b exp 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (rom_addr !== 9'd2 || rsp_valid !== 4'b0000) begin
            fails++;
            $display("FAIL inv_addr got a=%0d v=%b exp 2/0000", rom_addr, rsp_valid);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 4'b0000) begin
            fails++;
            $display("FAIL inv_early got %b exp 0000", rsp_valid);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'd142) begin
            fails++;
            $display("FAIL inv_rsp got v=%b d=%0d exp 0001/142", rsp_valid, rsp_data[7:0]);
        end
        rsp_ready = 4'b0001;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 4'b0000) begin
            fails++;
            $display("FAIL inv_clear got %b exp 0000", rsp_valid);
        end
        rsp_ready = '0;
    endtask

    task automatic test_log();
        req_valid = 4'b0010;
        req_op = 4'b0010;
        req_data[15:8] = 8'd3;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL log_grant got %b exp 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (rom_addr !== 9'd259) begin
            fails++;
            $display("FAIL log_addr got %0d exp 259", rom_addr);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_valid !== 4'b0010 || rsp_data[15:8] !== 8'd25) begin
            fails++;
            $display("FAIL log_rsp got v=%b d=%0d exp 0010/25", rsp_valid, rsp_data[15:8]);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        rsp_ready = '0;
        req_op = '0;
        // With all ports idle and requesting, the grant exposes rr_ptr.
        req_valid = 4'b1111;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL log_rr_ptr got %b exp 0100", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_contention();
        logic [7:0] cexp [4];
        cexp[0] = 8'd1;
        cexp[1] = 8'd142;
        cexp[2] = 8'd244;
        cexp[3] = 8'd71;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_op = '0;
        req_data = {8'd4, 8'd3, 8'd2, 8'd1};
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL cont_grant0 got %b exp 0001", req_ready);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (i <= 4) req_valid[i-1] = 1'b0;
            #1;
            if (i <= 3) begin
                tests++;
                if (req_ready !== 4'(1 << i)) begin
                    fails++;
                    $display("FAIL cont_grant%0d got %b exp %b", i, req_ready, 4'(1 << i));
                end
            end
            if (i >= 3 && i <= 6) begin
                tests++;
                if (rsp_valid !== 4'(1 << (i - 3)) || rsp_data[8*(i-3) +: 8] !== cexp[i-3]) begin
                    fails++;
                    $display("FAIL cont_rsp%0d got v=%b d=%0d exp %b/%0d", i - 3,
                             rsp_valid, rsp_data[8*(i-3) +: 8], 4'(1 << (i - 3)), cexp[i-3]);
                end
            end else begin
                tests++;
                if (rsp_valid !== 4'b0000) begin
                    fails++;
                    $display("FAIL cont_idle%0d got %b exp 0000", i, rsp_valid);
                end
            end
        end
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0100;
        req_op = '0;
        req_data[23:16] = 8'd3;
        rsp_ready = '0;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL bp_grant got %b exp 0100", req_ready);
        end
        repeat (3) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid[2] !== 1'b1 || rsp_data[23:16] !== 8'd244 || req_ready !== 4'b0000) begin
                fails++;
                $display("FAIL bp_hold%0d got v=%b d=%0d r=%b exp 1/244/0000",
                         c, rsp_valid[2], rsp_data[23:16], req_ready);
            end
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        #1;
        tests++;
        if (rsp_valid[2] !== 1'b0 || req_ready !== 4'b0100 || rsp_data[23:16] !== 8'd244) begin
            fails++;
            $display("FAIL bp_regrant got v=%b r=%b d=%0d exp 0/0100/244",
                     rsp_valid[2], req_ready, rsp_data[23:16]);
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_zero();
`ifdef RS_ROM_ARB_ZERO_CHK_EN
        zexp = 1'b1;
`else
        zexp = 1'b0;
`endif
        for (int op = 0; op < 2; op++) begin
            req_valid = 4'b1000;
            req_op = 4'(op << 3);
            req_data[31:24] = 8'd0;
            #1;
            tests++;
            if (req_ready !== 4'b1000) begin
                fails++;
                $display("FAIL zero_grant%0d got %b exp 1000", op, req_ready);
            end
            @(negedge clk);
            req_valid = '0;
            repeat (2) @(negedge clk);
            tests++;
            if (rsp_valid !== 4'b1000 || rsp_data[31:24] !== (op == 0 ? 8'd1 : 8'd255)
                || rsp_err !== {zexp, 3'b000}) begin
                fails++;
                $display("FAIL zero_rsp%0d got v=%b d=%0d e=%b exp 1000/%0d/%b", op,
                         rsp_valid, rsp_data[31:24], rsp_err, (op == 0 ? 1 : 255), {zexp, 3'b000});
            end
            rsp_ready = 4'b1000;
            @(negedge clk);
            tests++;
            if (rsp_valid !== 4'b0000 || rsp_err !== 4'b0000) begin
                fails++;
                $display("FAIL zero_clear%0d got v=%b e=%b exp 0000/0000", op, rsp_valid, rsp_err);
            end
            rsp_ready = '0;
        end
        req_op = '0;
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b0010;
        req_op = '0;
        req_data[15:8] = 8'd2;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL mid_grant got %b exp 0010", req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || rsp_err !== 4'b0000) begin
            fails++;
            $display("FAIL mid_rst_ctl got r=%b v=%b e=%b exp 0", req_ready, rsp_valid, rsp_err);
        end
        tests++;
        if (rsp_data !== 32'h0 || rom_addr !== 9'd0) begin
            fails++;
            $display("FAIL mid_rst_data got d=%h a=%0d exp 0/0", rsp_data, rom_addr);
        end
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 4'b0000) begin
                fails++;
                $display("FAIL mid_norsp%0d got %b exp 0000", c, rsp_valid);
            end
        end
        req_valid = 4'b1010;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL mid_first_grant got %b exp 0010", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_data = '0;
        rsp_ready = '0;
        build_rom();
        @(negedge clk);
        test_reset();
        test_inv();
        test_log();
        test_contention();
        test_backpressure();
        test_zero();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_rom_arb.md
RS_ROM_ARB -- requirements
Module: rs_rom_arb

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requester ports (2..8).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  input  NREQ  per-port lookup request.
REQ-005 SHALL have port: req_op  input  NREQ  per-port table select: 0 = GF(256) inverse, 1 = GF(256) log.
REQ-006 SHALL have port: req_data  input  8*NREQ  per-port operand; port k occupies bits [8k+7:8k].
REQ-007 SHALL have port: req_ready  output  NREQ  per-port grant; a request is accepted when req_valid & req_ready are both high at a rising edge.
REQ-008 SHALL have port: rsp_valid  output  NREQ  per-port result available.
REQ-009 SHALL have port: rsp_data  output  8*NREQ  per-port result, same packing as req_data.
REQ-010 SHALL have port: rsp_err  output  NREQ  per-port zero-operand flag (see Configuration).
REQ-011 SHALL have port: rsp_ready  input  NREQ  per-port result consumed.
REQ-012 SHALL have port: rom_addr  output  9  shared table address, {op, data}; registered.
REQ-013 SHALL have port: rom_q  input  8  shared table data; registered inside the table, valid one cycle after rom_addr.

Function
REQ-014 SHALL treat port k as eligible when req_valid[k]=1 and busy[k]=0; busy[k] is set on acceptance and cleared on the response handshake for port k.
REQ-015 SHALL grant at most one eligible port per cycle, round-robin: search starts at rr_ptr and wraps from NREQ-1 to 0.
REQ-016 SHALL drive req_ready combinationally: one-hot on the granted port, all zero when no port is eligible.
REQ-017 SHALL advance rr_ptr to (granted+1) mod NREQ on each acceptance and hold it otherwise.
REQ-018 SHALL register rom_addr = {req_op[k], req_data[k]} at the accepting edge E0, and hold rom_addr when nothing is accepted.
REQ-019 SHALL carry the granted port index and valid through two pipeline stages that match the table latency.
REQ-020 SHALL capture rom_q into rsp_data[k] and set rsp_valid[k] at edge E2, so rsp_valid rises two cycles after acceptance.
REQ-021 SHALL hold rsp_valid[k], rsp_data[k] and rsp_err[k] stable until rsp_ready[k]=1 at a rising edge, then clear rsp_valid[k] and busy[k] at that edge.
REQ-022 SHALL NOT re-grant port k in the same cycle its response handshake occurs; port k is eligible from the next cycle.
REQ-023 SHALL sustain one acceptance per cycle aggregate when different ports are eligible back to back, with at most one outstanding request per port.
REQ-024 SHALL ignore req_op and req_data of non-granted ports; rsp_data of idle ports SHALL retain its last value.

Reset
REQ-025 SHALL, while rst=1, force rr_ptr=0, busy=0, both pipeline valids=0, rsp_valid=0, rsp_data=0, rsp_err=0, rom_addr=0 and req_ready=0.
REQ-026 SHALL, when rst is asserted mid-operation, discard in-flight lookups with no rsp_valid produced for them; the first grant after reset release goes to the lowest eligible port index.

Configuration
REQ-027 SHALL use macro RS_ROM_ARB_ZERO_CHK_EN: when defined, rsp_err[k] is set alongside rsp_valid[k] if the accepted operand was 0 (inverse and log of 0 are undefined) and cleared with rsp_valid; when undefined, rsp_err is tied to 0 and no operand compare logic exists.

Verification
REQ-028 SHALL cover single inverse: port0 op=0 data=2 accepted at E0 -> rom_addr=2 after E0; rsp_valid[0]=1, rsp_data=142 at E2.
REQ-029 SHALL cover single log: port1 op=1 data=3 -> rom_addr=259; rsp_data[1]=25 at E2; with NREQ=4, rr_ptr=2 afterwards.
REQ-030 SHALL cover contention: all four ports valid from reset, rsp_ready=1 -> grants in order 0,1,2,3 on consecutive cycles, responses on consecutive cycles starting two cycles after the first grant.
REQ-031 SHALL cover backpressure: port2 inv(3) with rsp_ready[2]=0 for 5 cycles -> rsp_data[2]=244 held, req_ready[2]=0 throughout; regranted the cycle after rsp_ready[2]=1.
REQ-032 SHALL cover zero operand: port3 op=0 data=0 -> rsp_data=1 with rsp_err=1 when RS_ROM_ARB_ZERO_CHK_EN is defined, rsp_err=0 when it is undefined; op=1 data=0 -> rsp_data=255.
REQ-033 SHALL cover reset mid-flight: rst pulsed one cycle after acceptance -> no rsp_valid is produced and all outputs are at reset values.
